// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the round-robin multiplier-sharing scheduler.
package mult_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_RESP
   } state_e;

   localparam int N_REQ_DEF   = 4;
   localparam int W_DEF       = 8;
   localparam int TIMEOUT_DEF = 16;

   function automatic int cnt_width(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

   localparam int TO_CNT_W = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr, cyclically.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_grant
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!any_grant && req[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one sequential multiplier among N_REQ requesters: arbitrate, start, wait for done
// (or time out), then hand the product back over a per-requester valid/ready channel.
module mult_share_sched
   import mult_share_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               reset_a,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   rsp_valid,
   input  logic [N_REQ-1:0]   rsp_ready,
   output logic [2*W-1:0]     rsp_product,
   output logic               rsp_err,
   output logic               err_sticky,
   output logic [W-1:0]       mult_dataa,
   output logic [W-1:0]       mult_datab,
   output logic               mult_start,
   input  logic               mult_done,
   input  logic [2*W-1:0]     mult_product
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic [W-1:0]       opa_q, opa_d;
   logic [W-1:0]       opb_q, opb_d;
   logic               armed_q, armed_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]     prod_q, prod_d;
   logic               err_q, err_d;
   logic               sticky_q, sticky_d;
   logic               start_q, start_d;
   logic [N_REQ-1:0]   rspv_q, rspv_d;

   logic [N_REQ-1:0]   arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic [N_REQ-1:0]   gnt_onehot;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_grant (arb_any)
   );

   assign gnt_onehot = N_REQ'(1) << gnt_q;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      armed_d  = armed_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      err_d    = err_q;
      sticky_d = sticky_q;
      start_d  = 1'b0;
      rspv_d   = rspv_q;
      case (state_q)
         ST_IDLE: begin
            rspv_d = '0;
            if (arb_any) begin
               gnt_d   = arb_idx;
               opa_d   = req_a[arb_idx*W +: W];
               opb_d   = req_b[arb_idx*W +: W];
               ptr_d   = (arb_idx == IDX_W'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
               start_d = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            armed_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done still high from the previous job is ignored until done has been seen low.
            if (!mult_done) begin
               armed_d = 1'b1;
            end
            if (armed_q && mult_done) begin
               prod_d  = mult_product;
               err_d   = 1'b0;
               rspv_d  = gnt_onehot;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               prod_d   = '0;
               err_d    = 1'b1;
               sticky_d = 1'b1;
               rspv_d   = gnt_onehot;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready[gnt_q]) begin
               rspv_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         armed_q  <= 1'b0;
         cnt_q    <= '0;
         prod_q   <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         start_q  <= 1'b0;
         rspv_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         armed_q  <= armed_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         start_q  <= start_d;
         rspv_q   <= rspv_d;
      end
   end

   // The accept is combinational so the requester sees it in the grant cycle; forced low under reset.
   assign req_ready   = (state_q == ST_IDLE && !reset_a) ? arb_grant : '0;
   assign rsp_valid   = rspv_q;
   assign rsp_product = prod_q;
   assign rsp_err     = err_q;
   assign err_sticky  = sticky_q;
   assign mult_dataa  = opa_q;
   assign mult_datab  = opb_q;
   assign mult_start  = start_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Randomized bench for mult_share_sched with a job-level scoreboard and a behavioural multiplier.
module tb_mult_share_sched;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready = '0;
   logic [2*W-1:0] rsp_product;
   logic           rsp_err;
   logic           err_sticky;
   logic [W-1:0]   mult_dataa;
   logic [W-1:0]   mult_datab;
   logic           mult_start;
   logic           mdone;
   logic [2*W-1:0] mprod;

   always #5 clk = ~clk;

   mult_share_sched #(
      .N_REQ   (N),
      .W       (W),
      .TIMEOUT (16)
   ) dut (
      .clk          (clk),
      .reset_a      (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_product  (rsp_product),
      .rsp_err      (rsp_err),
      .err_sticky   (err_sticky),
      .mult_dataa   (mult_dataa),
      .mult_datab   (mult_datab),
      .mult_start   (mult_start),
      .mult_done    (mdone),
      .mult_product (mprod)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic expired(input string nm);
      total++;
      bad++;
      $display("FAIL %s actual=no-event required=event-within-budget", nm);
   endtask

   // Multiplier: 0 = done 5 cycles after start; 1 = done never rises;
   // 2 = done left high (stale, poisoned product) for 3 cycles, low, then high after 8.
   int mmode = 0;
   int mcnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdone <= 1'b0;
         mprod <= '0;
         mcnt  <= 0;
      end else if (mult_start) begin
         if (mmode == 0) begin
            mdone <= 1'b0;
            mcnt  <= 5;
         end else if (mmode == 1) begin
            mdone <= 1'b0;
            mcnt  <= 0;
         end else begin
            mprod <= 16'hDEAD;
            mcnt  <= 8;
         end
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 6) mdone <= 1'b0;
         if (mcnt == 1) begin
            mdone <= 1'b1;
            mprod <= 16'(mult_dataa) * 16'(mult_datab);
         end
      end
   end

   // Job-level reference: one outstanding job, round-robin pointer, fixed latency per multiplier mode.
   bit           busy_m   = 1'b0;
   bit           sticky_m = 1'b0;
   int           ptr_m    = 0;
   int           cyc      = 0;
   int           j_g, j_mode, j_start, lat, g;
   logic [7:0]   j_a, j_b;
   logic [15:0]  exp_p;
   logic [N-1:0] exp_v, exp_rdy;
   logic [N-1:0] xfer_n = '0;
   int           grant_log[$];

   always @(negedge clk) begin
      cyc++;
      xfer_n = req_valid & req_ready;
      if (rst) begin
         chk("rst_outs", 32'({req_ready, rsp_valid, rsp_product, rsp_err, err_sticky, mult_start}), 32'd0);
         chk("rst_opnd", 32'({mult_dataa, mult_datab}), 32'd0);
         busy_m   = 1'b0;
         ptr_m    = 0;
         sticky_m = 1'b0;
      end else begin
         if (!busy_m) begin
            exp_rdy = '0;
            g = -1;
            for (int k = 0; k < N; k++) begin
               if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            chk("start_idle", 32'(mult_start), 32'd0);
            if (g >= 0) begin
               busy_m  = 1'b1;
               j_g     = g;
               j_a     = req_a[g*W +: W];
               j_b     = req_b[g*W +: W];
               j_mode  = mmode;
               j_start = cyc + 1;
               ptr_m   = (g + 1) % N;
               grant_log.push_back(g);
            end
         end else begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            chk("mult_start", 32'(mult_start), 32'(cyc == j_start));
            if (cyc >= j_start) begin
               chk("mult_dataa", 32'(mult_dataa), 32'(j_a));
               chk("mult_datab", 32'(mult_datab), 32'(j_b));
            end
            lat   = (j_mode == 0) ? 7 : (j_mode == 1) ? 17 : 10;
            exp_v = '0;
            if (cyc >= j_start + lat) exp_v[j_g] = 1'b1;
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            if (exp_v != '0) begin
               exp_p = (j_mode == 1) ? 16'd0 : 16'(j_a) * 16'(j_b);
               if (j_mode == 1) sticky_m = 1'b1;
               chk("rsp_product", 32'(rsp_product), 32'(exp_p));
               chk("rsp_err", 32'(rsp_err), 32'(j_mode == 1));
               if (rsp_ready[j_g]) busy_m = 1'b0;
            end
         end
         chk("err_sticky", 32'(err_sticky), 32'(sticky_m));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      req_valid = req_valid & ~xfer_n;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]   = 1'b1;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   function automatic logic [7:0] rnd_op();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return 8'hFF;
      if (r == 1) return 8'h00;
      return 8'($urandom);
   endfunction

   task automatic wait_rsp(input int i, input logic [15:0] ep, input logic ee, input string nm);
      bit got = 1'b0;
      for (int k = 0; k < 80 && !got; k++) begin
         tick();
         @(negedge clk);
         #1;
         if (rsp_valid[i]) begin
            got = 1'b1;
            chk({nm, "_prod"}, 32'(rsp_product), 32'(ep));
            chk({nm, "_err"}, 32'(rsp_err), 32'(ee));
         end
      end
      if (!got) expired({nm, "_rsp_timeout"});
   endtask

   task automatic wait_idle(input string nm);
      bit done = 1'b0;
      rsp_ready = '1;
      for (int k = 0; k < 150 && !done; k++) begin
         tick();
         if (!busy_m && req_valid == '0) done = 1'b1;
      end
      if (!done) expired({nm, "_idle_timeout"});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst       = 1'b1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   int exp_ord[5] = '{0, 1, 2, 3, 0};
   int n0;

   initial begin
      repeat (2) @(posedge clk);
      #2;
      rst       = 1'b0;
      rsp_ready = '1;

      // Single job from requester 0.
      set_req(0, 8'd12, 8'd13);
      @(negedge clk);
      chk("t1_ready", 32'(req_ready), 32'h1);
      tick();
      @(negedge clk);
      chk("t1_start", 32'(mult_start), 32'd1);
      wait_rsp(0, 16'd156, 1'b0, "t1");
      wait_idle("t1");

      // All four requesting after reset: order 0,1,2,3,0.
      do_reset();
      grant_log.delete();
      for (int i = 0; i < N; i++) set_req(i, rnd_op(), rnd_op());
      for (int k = 0; k < 300 && grant_log.size() < 5; k++) begin
         tick();
         if (grant_log.size() < 5) begin
            for (int i = 0; i < N; i++) if (!req_valid[i]) set_req(i, rnd_op(), rnd_op());
         end
      end
      req_valid = '0;
      if (grant_log.size() < 5) expired("t2_grants");
      else for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), 32'(grant_log[i]), 32'(exp_ord[i]));
      wait_idle("t2");

      // Largest operands.
      set_req(2, 8'd255, 8'd255);
      wait_rsp(2, 16'hFE01, 1'b0, "t3");
      wait_idle("t3");

      // Back-pressure on requester 1 while requester 0 waits.
      rsp_ready = 4'b1101;
      set_req(1, 8'd7, 8'd9);
      tick();
      set_req(0, 8'd2, 8'd3);
      wait_rsp(1, 16'd63, 1'b0, "t4a");
      n0 = grant_log.size();
      for (int k = 0; k < 10; k++) begin
         tick();
         @(negedge clk);
         chk("t4_hold_valid", 32'(rsp_valid), 32'h2);
         chk("t4_hold_prod", 32'(rsp_product), 32'd63);
         chk("t4_hold_ready", 32'(req_ready), 32'd0);
      end
      chk("t4_no_grant", 32'(grant_log.size()), 32'(n0));
      tick();
      rsp_ready = '1;
      wait_rsp(0, 16'd6, 1'b0, "t4b");
      wait_idle("t4");

      // Timeout, then a normal job.
      mmode = 1;
      set_req(3, 8'd3, 8'd4);
      wait_rsp(3, 16'd0, 1'b1, "t5");
      chk("t5_sticky", 32'(err_sticky), 32'd1);
      wait_idle("t5");
      mmode = 0;
      set_req(0, 8'd5, 8'd6);
      wait_rsp(0, 16'd30, 1'b0, "t5b");
      wait_idle("t5b");

      // Stale done, then reset in the middle of a job.
      mmode = 2;
      set_req(1, 8'd11, 8'd11);
      wait_rsp(1, 16'd121, 1'b0, "t6a");
      wait_idle("t6a");
      mmode = 0;
      set_req(2, 8'd9, 8'd9);
      repeat (3) tick();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_outs", 32'({req_ready, rsp_valid, rsp_product, rsp_err, err_sticky, mult_start}), 32'd0);
      chk("t6_rst_opnd", 32'({mult_dataa, mult_datab}), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst       = 1'b0;
      req_valid = '0;
      set_req(0, 8'd4, 8'd4);
      set_req(2, 8'd9, 8'd9);
      @(negedge clk);
      chk("t6_first_grant", 32'(req_ready), 32'h1);
      wait_idle("t6");

      // Random traffic in batches, multiplier behaviour fixed per batch.
      for (int batch = 0; batch < 10; batch++) begin
         mmode = (batch == 4) ? 1 : (($urandom_range(0, 2) == 0) ? 2 : 0);
         for (int k = 0; k < 300; k++) begin
            tick();
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
               if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rnd_op(), rnd_op());
               else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
         end
         req_valid = '0;
         wait_idle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
